// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Drives packed BCD digits for the board-test seven-segment display path.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SR_W  = 4 * DIGITS + WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                state;
    logic [4*DIGITS-1:0]   bcd_acc;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [WIDTH-1:0]      bin_sh;
    logic [CNT_W-1:0]      bit_cnt;
    logic [SR_W-1:0]       shifted;
    logic                  last_shift;

    // Every digit >= 5 gets +3 so that the following left shift carries correctly into the next digit.
    always_comb begin
        bcd_adj = bcd_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_acc[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign shifted    = {bcd_adj, bin_sh} << 1;
    assign last_shift = (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd_acc <= '0;
            bin_sh  <= '0;
            bit_cnt <= '0;
            bcd_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_sh  <= bin_in;
                        bcd_acc <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                SHIFT: begin
                    {bcd_acc, bin_sh} <= shifted;
                    bit_cnt           <= bit_cnt + CNT_W'(1);
                    // The result register only updates once all WIDTH bits are in, so no partial value escapes.
                    if (last_shift) begin
                        bcd_out <= shifted[SR_W-1 -: 4*DIGITS];
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a decimal-digit reference model feeds a result queue
// that is popped and compared whenever the converter pulses done.
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int BOUND  = 60;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [WIDTH-1:0]     bin_in;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  bcd_out;

    logic [4*DIGITS-1:0]  exp_q[$];
    int                   checks;
    int                   errors;
    int                   cycle;
    int                   done_count;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference uses repeated division by ten, independent of the shift-and-add-3 structure.
    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned value);
        logic [4*DIGITS-1:0] res;
        int unsigned v;
        res = '0;
        v   = value;
        for (int k = 0; k < DIGITS; k++) begin
            res[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge and any done pulse is scored.
    task automatic tick();
        logic [4*DIGITS-1:0] exp;
        @(posedge clk);
        #1;
        cycle++;
        checkOutput("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
        if (done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp = exp_q.pop_front();
                checkOutput("bcd_result", 32'(bcd_out), 32'(exp));
            end
        end
    endtask

    task automatic applyStimulus(input int unsigned value);
        start  = 1'b1;
        bin_in = WIDTH'(value);
        exp_q.push_back(to_bcd(value));
        tick();
        start  = 1'b0;
    endtask

    // Runs until done; reports edges after the accepting edge and busy cycles seen.
    task automatic waitDone(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < BOUND; i++) begin
            tick();
            edges++;
            if (done === 1'b1) return;
            if (busy === 1'b1) busy_cycles++;
        end
        checkOutput("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic runConv(input int unsigned value);
        int edges;
        int busy_cycles;
        applyStimulus(value);
        waitDone(edges, busy_cycles);
        checkOutput("done_latency", 32'(edges), 32'(WIDTH));
        checkOutput("busy_cycles", 32'(busy_cycles), 32'(WIDTH));
        tick();
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("bcd_hold", 32'(bcd_out), 32'(to_bcd(value)));
    endtask

    initial begin
        int edges;
        int busy_cycles;
        int first_done;
        int gap_idle;
        int dc_before;

        checks     = 0;
        errors     = 0;
        cycle      = 0;
        done_count = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        bin_in     = '0;

        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_bcd", 32'(bcd_out), 32'd0);

        $display("[TB] single conversions");
        runConv(0);
        runConv(65535);
        runConv(1234);
        runConv(9999);

        $display("[TB] start during SHIFT is ignored");
        dc_before = done_count;
        applyStimulus(1234);
        for (int i = 0; i < 4; i++) tick();
        start  = 1'b1;
        bin_in = 16'd42;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        checkOutput("ignored_start_pulses", 32'(done_count - dc_before), 32'd1);
        checkOutput("ignored_start_hold", 32'(bcd_out), 32'h01234);

        $display("[TB] back-to-back with start held");
        start  = 1'b1;
        bin_in = 16'd100;
        exp_q.push_back(to_bcd(100));
        tick();
        waitDone(edges, busy_cycles);
        first_done = cycle;
        bin_in = 16'd7;
        exp_q.push_back(to_bcd(7));
        gap_idle = 0;
        edges    = 0;
        for (int i = 0; i < BOUND; i++) begin
            tick();
            edges++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) gap_idle++;
        end
        start = 1'b0;
        checkOutput("b2b_done_spacing", 32'(cycle - first_done), 32'(WIDTH + 1));
        checkOutput("b2b_busy_gap", 32'(gap_idle), 32'd0);
        checkOutput("b2b_second_bcd", 32'(bcd_out), 32'h00007);
        tick();
        checkOutput("b2b_return_idle", {31'd0, busy | done}, 32'd0);

        $display("[TB] reset aborts a conversion");
        runConv(65535);
        applyStimulus(500);
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        checkOutput("abort_bcd", 32'(bcd_out), 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        dc_before = done_count;
        for (int i = 0; i < 25; i++) tick();
        checkOutput("abort_no_done", 32'(done_count - dc_before), 32'd0);
        checkOutput("abort_idle_busy", {31'd0, busy}, 32'd0);
        runConv(321);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
